market_feed_parser: RTL and testbench
=====================================

// Module: market_feed_parser
// PURPOSE
//  Upstream stage of the network interface. Parses framed market-data words from the 10G MAC
//  (156.25 MHz domain), checks each frame, and emits one 64-bit price-pair word per good frame
//  as rx_data/rx_valid. Also tracks sequence gaps and keeps saturating error and frame counters.
// PARAMETERS
//  MAGIC     16'hC0DE  required header magic, hdr[63:48]
//  PRICE_TYP 8'h01     msg_type that carries a price pair, hdr[31:24]
//  TIMEOUT   16        consecutive in_valid=0 cycles mid-frame before the frame is aborted
//  CNT_W     32        width of the statistics counters
// PORTS
//  clk_156mhz  in   1      sole clock
//  rst_n       in   1      synchronous, active-low reset
//  in_data     in   64     MAC word
//  in_valid    in   1      in_data valid; no backpressure, parser always accepts
//  in_sop      in   1      first word of frame (qualified by in_valid)
//  in_eop      in   1      last word of frame (qualified by in_valid)
//  rx_data     out  64     price pair {btc[31:0], eth[31:0]}
//  rx_valid    out  1      one-cycle pulse, rx_data valid
//  last_seq    out  16     seq of most recent checksum-good frame
//  frames_ok   out  CNT_W  frames emitted on rx_valid
//  frames_err  out  CNT_W  frames dropped (magic, length, checksum or timeout error)
//  seq_gaps    out  CNT_W  emitted frames whose seq != previous good seq + 1
// BEHAVIOUR
//  Frame = exactly 3 beats: HDR, PAYLOAD, TRAILER.
//   HDR = {magic[63:48], seq[47:32], type[31:24], rsvd[23:0]}; rsvd is ignored.
//   TRAILER = HDR ^ PAYLOAD (64-bit XOR).
//  Reset (rst_n=0 at a clock edge):
//   - state=IDLE; all outputs 0; seq_valid=0; idle_cnt=0.
//   - A partial frame in flight is dropped and is not counted.
//  FSM states: IDLE, PAYLOAD, TRAILER, DISCARD. Beats with in_valid=0 never change state.
//  IDLE, on in_valid:
//   - !sop: beat ignored.
//   - sop&eop: frames_err++.
//   - sop, magic bad: frames_err++, ->DISCARD.
//   - sop, magic ok: latch HDR, ->PAYLOAD.
//  PAYLOAD, on in_valid:
//   - sop: frames_err++ for the aborted frame; new beat processed as a header, same rules as IDLE.
//   - eop: frames_err++, ->IDLE.
//   - else: latch PAYLOAD, ->TRAILER.
//  TRAILER, on in_valid:
//   - sop: abort, same as PAYLOAD.
//   - !eop: frames_err++, ->DISCARD (frame too long).
//   - eop, checksum bad: frames_err++, ->IDLE.
//   - eop, checksum ok: last_seq<=seq, seq_valid<=1, ->IDLE. Then:
//     * type==PRICE_TYP: rx_data<=PAYLOAD, rx_valid=1 on the next cycle (latency 1 from the
//       trailer beat), frames_ok++. If seq_valid && seq != last_seq+1 (mod 2^16): seq_gaps++.
//     * other types: no emit, no counter change.
//  DISCARD, on in_valid:
//   - eop&!sop: ->IDLE.
//   - sop: processed as a header, same rules as IDLE; no extra error count.
//  Timeout: idle_cnt clears on every in_valid beat and counts in_valid=0 cycles in PAYLOAD or
//   TRAILER. On the TIMEOUT-th consecutive idle cycle: frames_err++, ->IDLE. A gap of TIMEOUT-1
//   cycles is tolerated. DISCARD has no timeout.
//  Each dropped frame increments frames_err exactly once.
//  rx_data holds its last value between pulses.
//  Counters saturate at 2^CNT_W-1 and never wrap.
// TESTING
//  1 HDR=64'hC0DE_0001_0100_0000, PAY=64'h0000_6A5C_0000_0C1C, TRL=HDR^PAY on back-to-back
//    beats -> rx_valid 1 cycle after TRL, rx_data=PAY, frames_ok=1, last_seq=16'h0001.
//  2 Same frame, TRL^64'h1 -> no rx_valid, frames_err=1, last_seq unchanged.
//  3 Good frames seq 1 then 3 -> both emitted, seq_gaps=1. Then seq 16'hFFFF then 16'h0000 ->
//    seq_gaps still 1 (wrap is not a gap).
//  4 Magic 16'hBEEF, 3 beats, eop on the 3rd, followed immediately by a good frame ->
//    frames_err=1, good frame emitted normally.
//  5 SOP asserted on the TRAILER beat, then that beat + 2 more forming a good frame ->
//    frames_err=1, second frame emitted.
//  6 HDR, then 15 idle cycles, PAY, TRL -> emitted. HDR, then 16 idle cycles -> frames_err++,
//    FSM in IDLE, a later PAY-only beat (no sop) is ignored.

Source files
------------

// File: rtl/market_feed_parser.sv
// Market-data frame parser: validates 3-beat HDR/PAYLOAD/TRAILER frames from the MAC,
// emits one price-pair word per good price frame and keeps saturating statistics.
module market_feed_parser #(
  parameter logic [15:0] MAGIC     = 16'hC0DE,
  parameter logic [7:0]  PRICE_TYP = 8'h01,
  parameter int          TIMEOUT   = 16,
  parameter int          CNT_W     = 32
) (
  input  logic             clk_156mhz,
  input  logic             rst_n,
  input  logic [63:0]      in_data,
  input  logic             in_valid,
  input  logic             in_sop,
  input  logic             in_eop,
  output logic [63:0]      rx_data,
  output logic             rx_valid,
  output logic [15:0]      last_seq,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_err,
  output logic [CNT_W-1:0] seq_gaps
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_TRAILER = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        hdr_q, hdr_d;
  logic [63:0]        pay_q, pay_d;
  logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
  logic [15:0]        last_seq_q, last_seq_d;
  logic               seq_valid_q, seq_valid_d;
  logic [63:0]        rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic [CNT_W-1:0]   frames_ok_q, frames_ok_d;
  logic [CNT_W-1:0]   frames_err_q, frames_err_d;
  logic [CNT_W-1:0]   seq_gaps_q, seq_gaps_d;

  logic [1:0]  err_inc;
  logic        ok_inc;
  logic        gap_inc;
  logic        hdr_beat;
  logic [15:0] hdr_seq;
  logic [7:0]  hdr_type;

  assign hdr_seq  = hdr_q[47:32];
  assign hdr_type = hdr_q[31:24];

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] inc);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    pay_d       = pay_q;
    idle_cnt_d  = idle_cnt_q;
    last_seq_d  = last_seq_q;
    seq_valid_d = seq_valid_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    err_inc     = 2'd0;
    ok_inc      = 1'b0;
    gap_inc     = 1'b0;
    hdr_beat    = 1'b0;

    if (in_valid) begin
      idle_cnt_d = '0;
      case (state_q)
        S_IDLE: hdr_beat = in_sop;
        S_PAYLOAD: begin
          if (in_sop) begin
            err_inc  = 2'd1;
            hdr_beat = 1'b1;
          end else if (in_eop) begin
            err_inc = 2'd1;
            state_d = S_IDLE;
          end else begin
            pay_d   = in_data;
            state_d = S_TRAILER;
          end
        end
        S_TRAILER: begin
          if (in_sop) begin
            err_inc  = 2'd1;
            hdr_beat = 1'b1;
          end else if (!in_eop) begin
            err_inc = 2'd1;
            state_d = S_DISCARD;
          end else if (in_data != (hdr_q ^ pay_q)) begin
            err_inc = 2'd1;
            state_d = S_IDLE;
          end else begin
            state_d     = S_IDLE;
            last_seq_d  = hdr_seq;
            seq_valid_d = 1'b1;
            // Non-price frames still advance the sequence tracker but emit nothing.
            if (hdr_type == PRICE_TYP) begin
              rx_valid_d = 1'b1;
              rx_data_d  = pay_q;
              ok_inc     = 1'b1;
              gap_inc    = seq_valid_q && (hdr_seq != (last_seq_q + 16'd1));
            end
          end
        end
        S_DISCARD: begin
          if (in_sop) hdr_beat = 1'b1;
          else if (in_eop) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // A new SOP beat may add a second error on top of an aborted frame.
      if (hdr_beat) begin
        if (in_eop) begin
          err_inc = err_inc + 2'd1;
          state_d = S_IDLE;
        end else if (in_data[63:48] != MAGIC) begin
          err_inc = err_inc + 2'd1;
          state_d = S_DISCARD;
        end else begin
          hdr_d   = in_data;
          state_d = S_PAYLOAD;
        end
      end
    end else if ((state_q == S_PAYLOAD) || (state_q == S_TRAILER)) begin
      if (idle_cnt_q == IDLE_LAST) begin
        err_inc    = 2'd1;
        state_d    = S_IDLE;
        idle_cnt_d = '0;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end else begin
      idle_cnt_d = '0;
    end

    frames_ok_d  = sat_add(frames_ok_q, {1'b0, ok_inc});
    frames_err_d = sat_add(frames_err_q, err_inc);
    seq_gaps_d   = sat_add(seq_gaps_q, {1'b0, gap_inc});
  end

  always_ff @(posedge clk_156mhz) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      hdr_q        <= '0;
      pay_q        <= '0;
      idle_cnt_q   <= '0;
      last_seq_q   <= '0;
      seq_valid_q  <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frames_ok_q  <= '0;
      frames_err_q <= '0;
      seq_gaps_q   <= '0;
    end else begin
      state_q      <= state_d;
      hdr_q        <= hdr_d;
      pay_q        <= pay_d;
      idle_cnt_q   <= idle_cnt_d;
      last_seq_q   <= last_seq_d;
      seq_valid_q  <= seq_valid_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frames_ok_q  <= frames_ok_d;
      frames_err_q <= frames_err_d;
      seq_gaps_q   <= seq_gaps_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign last_seq   = last_seq_q;
  assign frames_ok  = frames_ok_q;
  assign frames_err = frames_err_q;
  assign seq_gaps   = seq_gaps_q;

endmodule

// File: tb/tb_market_feed_parser.sv
// Directed bench for market_feed_parser: a table of whole frames with cumulative
// expected statistics, plus hand-written abort, discard and timeout sequences.
module tb_market_feed_parser;

  localparam int CNT_W = 32;

  logic             clk_156mhz;
  logic             rst_n;
  logic [63:0]      in_data;
  logic             in_valid;
  logic             in_sop;
  logic             in_eop;
  logic [63:0]      rx_data;
  logic             rx_valid;
  logic [15:0]      last_seq;
  logic [CNT_W-1:0] frames_ok;
  logic [CNT_W-1:0] frames_err;
  logic [CNT_W-1:0] seq_gaps;

  int checks;
  int errors;

  market_feed_parser dut (
    .clk_156mhz (clk_156mhz),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sop     (in_sop),
    .in_eop     (in_eop),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .last_seq   (last_seq),
    .frames_ok  (frames_ok),
    .frames_err (frames_err),
    .seq_gaps   (seq_gaps)
  );

  // clock / reset
  initial clk_156mhz = 1'b0;
  always #5 clk_156mhz = ~clk_156mhz;

  typedef struct {
    logic [63:0] hdr;
    logic [63:0] pay;
    logic [63:0] trl_flip;
    logic        exp_valid;
    logic [63:0] exp_data;
    logic [31:0] exp_ok;
    logic [31:0] exp_err;
    logic [31:0] exp_gaps;
    logic [15:0] exp_seq;
  } frame_vec_t;

  frame_vec_t vecs[6];

  function automatic logic [63:0] mk_hdr(input logic [15:0] magic, input logic [15:0] seq,
                                         input logic [7:0] typ, input logic [23:0] rsvd);
    return {magic, seq, typ, rsvd};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks: each beat occupies one clock, outputs sampled 1 ns after the edge
  task automatic beat(input logic s, input logic e, input logic [63:0] d);
    in_valid = 1'b1;
    in_sop   = s;
    in_eop   = e;
    in_data  = d;
    @(posedge clk_156mhz);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_156mhz);
      #1;
    end
  endtask

  task automatic send_frame(input logic [63:0] hdr, input logic [63:0] pay,
                            input logic [63:0] flip);
    beat(1'b1, 1'b0, hdr);
    beat(1'b0, 1'b0, pay);
    beat(1'b0, 1'b1, hdr ^ pay ^ flip);
  endtask

  task automatic check_stats(input string tag, input logic [31:0] ok, input logic [31:0] err,
                             input logic [31:0] gaps, input logic [15:0] seq);
    check({tag, ".frames_ok"}, 64'(frames_ok), 64'(ok));
    check({tag, ".frames_err"}, 64'(frames_err), 64'(err));
    check({tag, ".seq_gaps"}, 64'(seq_gaps), 64'(gaps));
    check({tag, ".last_seq"}, 64'(last_seq), 64'(seq));
  endtask

  localparam logic [63:0] PAY0 = 64'h0000_6A5C_0000_0C1C;
  localparam logic [63:0] P3   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] P4   = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] P5   = 64'h0102_0304_0506_0708;
  localparam logic [63:0] P6   = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] P7   = 64'hA5A5_0000_5A5A_0001;
  localparam logic [63:0] P8   = 64'h0BAD_0BAD_0BAD_0BAD;
  localparam logic [63:0] P9   = 64'h0000_7000_0000_0E00;
  localparam logic [63:0] P10  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] P11  = 64'h0F0F_0F0F_F0F0_F0F0;

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_data  = '0;

    // Cumulative expectations; FFFE is a non-price frame so FFFF and its 0000 wrap are not gaps.
    vecs[0] = '{mk_hdr(16'hC0DE, 16'h0001, 8'h01, 24'h0), PAY0, 64'h0, 1'b1, PAY0, 1, 0, 0, 16'h0001};
    vecs[1] = '{mk_hdr(16'hC0DE, 16'h0001, 8'h01, 24'h0), PAY0, 64'h1, 1'b0, PAY0, 1, 1, 0, 16'h0001};
    vecs[2] = '{mk_hdr(16'hC0DE, 16'h0003, 8'h01, 24'h0), P3,   64'h0, 1'b1, P3,   2, 1, 1, 16'h0003};
    vecs[3] = '{mk_hdr(16'hC0DE, 16'hFFFE, 8'h02, 24'h0), P4,   64'h0, 1'b0, P3,   2, 1, 1, 16'hFFFE};
    vecs[4] = '{mk_hdr(16'hC0DE, 16'hFFFF, 8'h01, 24'h0), P5,   64'h0, 1'b1, P5,   3, 1, 1, 16'hFFFF};
    vecs[5] = '{mk_hdr(16'hC0DE, 16'h0000, 8'h01, 24'hABCDEF), P6, 64'h0, 1'b1, P6, 4, 1, 1, 16'h0000};

    repeat (3) @(posedge clk_156mhz);
    #1;
    rst_n = 1'b1;
    check("reset.rx_valid", 64'(rx_valid), 64'h0);
    check("reset.rx_data", rx_data, 64'h0);
    check_stats("reset", 0, 0, 0, 16'h0000);

    // table-driven frames
    for (int i = 0; i < 6; i++) begin
      send_frame(vecs[i].hdr, vecs[i].pay, vecs[i].trl_flip);
      check($sformatf("vec%0d.rx_valid", i), 64'(rx_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d.rx_data", i), rx_data, vecs[i].exp_data);
      check_stats($sformatf("vec%0d", i), vecs[i].exp_ok, vecs[i].exp_err,
                  vecs[i].exp_gaps, vecs[i].exp_seq);
      idle(1);
      check($sformatf("vec%0d.pulse_end", i), 64'(rx_valid), 64'h0);
      check($sformatf("vec%0d.rx_hold", i), rx_data, vecs[i].exp_data);
    end

    // bad magic frame discarded to its eop, then a good frame right behind it
    beat(1'b1, 1'b0, mk_hdr(16'hBEEF, 16'h0009, 8'h01, 24'h0));
    beat(1'b0, 1'b0, P6);
    beat(1'b0, 1'b1, 64'h0);
    check("magic.err", 64'(frames_err), 64'd2);
    send_frame(mk_hdr(16'hC0DE, 16'h0001, 8'h01, 24'h0), P7, 64'h0);
    check("magic.rx_valid", 64'(rx_valid), 64'h1);
    check("magic.rx_data", rx_data, P7);
    check_stats("magic", 5, 2, 1, 16'h0001);

    // sop on the trailer beat aborts the first frame and starts a new one
    beat(1'b1, 1'b0, mk_hdr(16'hC0DE, 16'h0005, 8'h01, 24'h0));
    beat(1'b0, 1'b0, P8);
    send_frame(mk_hdr(16'hC0DE, 16'h0002, 8'h01, 24'h0), P9, 64'h0);
    check("abort.rx_valid", 64'(rx_valid), 64'h1);
    check("abort.rx_data", rx_data, P9);
    check_stats("abort", 6, 3, 1, 16'h0002);

    // a gap of TIMEOUT-1 idle cycles is tolerated
    beat(1'b1, 1'b0, mk_hdr(16'hC0DE, 16'h0003, 8'h01, 24'h0));
    idle(15);
    check("gap15.err", 64'(frames_err), 64'd3);
    beat(1'b0, 1'b0, P10);
    beat(1'b0, 1'b1, mk_hdr(16'hC0DE, 16'h0003, 8'h01, 24'h0) ^ P10);
    check("gap15.rx_valid", 64'(rx_valid), 64'h1);
    check("gap15.rx_data", rx_data, P10);
    check_stats("gap15", 7, 3, 1, 16'h0003);

    // TIMEOUT idle cycles abort the frame; later beats without sop are ignored
    beat(1'b1, 1'b0, mk_hdr(16'hC0DE, 16'h0004, 8'h01, 24'h0));
    idle(15);
    check("tmo.before", 64'(frames_err), 64'd3);
    idle(1);
    check("tmo.err", 64'(frames_err), 64'd4);
    beat(1'b0, 1'b0, P11);
    beat(1'b0, 1'b1, mk_hdr(16'hC0DE, 16'h0004, 8'h01, 24'h0) ^ P11);
    check("tmo.ignored_valid", 64'(rx_valid), 64'h0);
    check_stats("tmo.ignored", 7, 4, 1, 16'h0003);

    // single-beat sop&eop frame is an error; the next good frame skips seq 4 -> gap
    beat(1'b1, 1'b1, mk_hdr(16'hC0DE, 16'h0004, 8'h01, 24'h0));
    check("short.err", 64'(frames_err), 64'd5);
    send_frame(mk_hdr(16'hC0DE, 16'h0005, 8'h01, 24'h0), P11, 64'h0);
    check("after.rx_valid", 64'(rx_valid), 64'h1);
    check("after.rx_data", rx_data, P11);
    check_stats("after", 8, 5, 2, 16'h0005);

    // mid-frame reset drops the partial frame without counting it
    beat(1'b1, 1'b0, mk_hdr(16'hC0DE, 16'h0006, 8'h01, 24'h0));
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    check("rst2.rx_data", rx_data, 64'h0);
    check_stats("rst2", 0, 0, 0, 16'h0000);
    beat(1'b0, 1'b0, P5);
    beat(1'b0, 1'b1, mk_hdr(16'hC0DE, 16'h0006, 8'h01, 24'h0) ^ P5);
    check("rst2.rx_valid", 64'(rx_valid), 64'h0);
    check_stats("rst2.after", 0, 0, 0, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
